// File: rtl/l1_line_writeback_if.sv
// Outbound writeback beat bus from the L1 victim-line drain engine to the L2/memory write channel.
// Latency: none, this is a wiring bundle only.
// Backpressure: valid/ready; the master holds a beat stable until it sees out_ready with out_valid.
interface l1_line_writeback_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OFF_W      = 2
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [OFF_W-1:0]      out_idx;
    logic                  out_last;

    modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/l1_line_writeback.sv
// Drains one L1 data-cache line from the data BRAM read port onto the writeback beat bus.
// Latency: first beat valid 2 cycles after start is accepted; one beat per cycle when the sink is ready.
// Backpressure: 2-entry skid buffer with read-issue credit; issue stalls when buffer + in-flight reach 2.
module l1_line_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WORDS = 4,
    localparam int OFF_W     = $clog2(LINE_WORDS)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic [ADDR_WIDTH-OFF_W-1:0] line_idx,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_WIDTH-1:0]       bram_raddr,
    input  logic [DATA_WIDTH-1:0]       bram_dout,
    l1_line_writeback_if.master         wb
);
    localparam logic [OFF_W:0]   CNT_END  = (OFF_W+1)'(LINE_WORDS);
    localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(LINE_WORDS-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [ADDR_WIDTH-OFF_W-1:0] line_lat;
    logic [OFF_W:0]              rd_cnt;
    logic                        inflight;
    logic [OFF_W-1:0]            infl_idx;
    logic [ADDR_WIDTH-1:0]       raddr_q;

    // Skid buffer: two entries of {data, offset}, pointer-indexed.
    logic [DATA_WIDTH-1:0]       fifo_dat [2];
    logic [OFF_W-1:0]            fifo_idx [2];
    logic                        wr_ptr;
    logic                        rd_ptr;
    logic [1:0]                  occ;

    logic                        accept;
    logic                        pop;
    logic                        push;
    logic [1:0]                  occ_next;
    logic                        issue;

    assign accept   = (state == S_IDLE) && start;
    assign pop      = wb.out_valid && wb.out_ready;
    // Data for a read issued last cycle is on bram_dout now.
    assign push     = inflight;
    assign occ_next = occ - {1'b0, pop};
    // Credit counts buffered words after this cycle's pop plus the word still in the BRAM pipe,
    // so a read is only launched when its data is guaranteed a free slot.
    assign issue    = (state == S_RUN) && (rd_cnt != CNT_END)
                      && ((occ_next + {1'b0, inflight}) < 2'd2);

    assign bram_raddr   = issue ? {line_lat, rd_cnt[OFF_W-1:0]} : raddr_q;

    assign wb.out_valid = (occ != 2'd0);
    assign wb.out_data  = fifo_dat[rd_ptr];
    assign wb.out_idx   = fifo_idx[rd_ptr];
    assign wb.out_last  = wb.out_valid && (fifo_idx[rd_ptr] == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave RUN only when the final beat is taken by the sink.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (pop && wb.out_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_RUN:   busy = 1'b1;
            S_DONE:  begin busy = 1'b1; done = 1'b1; end
            default: begin busy = 1'b0; done = 1'b0; end
        endcase
    end

    // Read-issue counters, BRAM pipe tracking and skid-buffer bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_lat <= '0;
            rd_cnt   <= '0;
            inflight <= 1'b0;
            infl_idx <= '0;
            raddr_q  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_dat[i] <= '0;
                fifo_idx[i] <= '0;
            end
        end else begin
            raddr_q <= bram_raddr;
            if (accept) begin
                line_lat <= line_idx;
                rd_cnt   <= '0;
                inflight <= 1'b0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                occ      <= 2'd0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    rd_cnt   <= rd_cnt + 1'b1;
                    infl_idx <= rd_cnt[OFF_W-1:0];
                end
                if (push) begin
                    fifo_dat[wr_ptr] <= bram_dout;
                    fifo_idx[wr_ptr] <= infl_idx;
                    wr_ptr           <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                occ <= occ + {1'b0, push} - {1'b0, pop};
            end
        end
    end
endmodule

// File: tb/tb_l1_line_writeback.sv
// Directed bench for l1_line_writeback with a behavioural BRAM and a beat scoreboard.
// Latency: drives inputs 1 time unit after the rising edge, samples at the falling edge.
// Backpressure: out_ready is held high, held low, or toggled pseudo-randomly per test.
module tb_l1_line_writeback;
    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [5:0]  line_idx;
    logic        busy;
    logic        done;
    logic [7:0]  bram_raddr;
    logic [31:0] bram_dout = 32'd0;

    logic [31:0] mem [256];

    int n_chk  = 0;
    int n_fail = 0;

    // Monitor state, written only at the falling edge.
    logic [34:0] beat_q [$];
    int          n_iss;
    int          n_pop;
    int          n_done;
    int          max_out;
    logic [7:0]  prev_raddr = 8'd0;

    l1_line_writeback_if #(.DATA_WIDTH(32), .OFF_W(2)) wb ();

    l1_line_writeback #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .LINE_WORDS(4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .line_idx   (line_idx),
        .busy       (busy),
        .done       (done),
        .bram_raddr (bram_raddr),
        .bram_dout  (bram_dout),
        .wb         (wb)
    );

    always #5 clk = ~clk;

    // Synchronous-read BRAM model.
    always @(posedge clk) bram_dout <= mem[bram_raddr];

    // Record beats that will handshake at the next edge, count read issues and done pulses.
    always @(negedge clk) begin
        if (wb.out_valid && wb.out_ready) begin
            beat_q.push_back({wb.out_last, wb.out_idx, wb.out_data});
            n_pop = n_pop + 1;
        end
        if (busy && bram_raddr != prev_raddr) n_iss = n_iss + 1;
        prev_raddr = bram_raddr;
        if (n_iss - n_pop > max_out) max_out = n_iss - n_pop;
        if (done) n_done = n_done + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        beat_q.delete();
        n_iss   = 0;
        n_pop   = 0;
        n_done  = 0;
        max_out = 0;
    endtask

    task automatic start_line(input logic [5:0] li);
        line_idx = li;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Returns in the DONE cycle, or reports a timeout.
    task automatic wait_done(input bit rnd, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            if (rnd) wb.out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic check_line(input logic [5:0] li);
        logic [34:0] b;
        logic [1:0]  k2;
        chk("beat_count", beat_q.size(), 4);
        for (int k = 0; k < beat_q.size() && k < 4; k++) begin
            b  = beat_q[k];
            k2 = k[1:0];
            chk("beat_data", b[31:0], mem[{li, k2}]);
            chk("beat_idx", b[33:32], k2);
            chk("beat_last", b[34], (k == 3));
        end
        chk("done_count", n_done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tot_done;
        int n;
        logic [5:0] li;

        for (int i = 0; i < 256; i++) mem[i] = 32'h98 + i;
        start        = 1'b0;
        line_idx     = 6'd0;
        wb.out_ready = 1'b0;
        clear_mon();
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy}, 0);
        chk("rst_done", {63'd0, done}, 0);
        chk("rst_valid", {63'd0, wb.out_valid}, 0);
        chk("rst_last", {63'd0, wb.out_last}, 0);
        chk("rst_data", wb.out_data, 0);
        chk("rst_idx", wb.out_idx, 0);
        chk("rst_raddr", bram_raddr, 0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Basic drain of line 2 with the sink always ready: cycle-exact timing.
        clear_mon();
        wb.out_ready = 1'b1;
        start_line(6'd2);
        chk("b_busy_c1", {63'd0, busy}, 1);
        chk("b_raddr_c1", bram_raddr, 8);
        tick();
        chk("b_raddr_c2", bram_raddr, 9);
        chk("b_valid_c2", {63'd0, wb.out_valid}, 0);
        tick();
        chk("b_raddr_c3", bram_raddr, 10);
        chk("b_valid_c3", {63'd0, wb.out_valid}, 1);
        chk("b_data_c3", wb.out_data, 32'hA0);
        tick();
        chk("b_raddr_c4", bram_raddr, 11);
        chk("b_data_c4", wb.out_data, 32'hA1);
        tick();
        chk("b_raddr_hold", bram_raddr, 11);
        chk("b_data_c5", wb.out_data, 32'hA2);
        chk("b_last_c5", {63'd0, wb.out_last}, 0);
        tick();
        chk("b_data_c6", wb.out_data, 32'hA3);
        chk("b_last_c6", {63'd0, wb.out_last}, 1);
        tick();
        chk("b_done_c7", {63'd0, done}, 1);
        chk("b_busy_c7", {63'd0, busy}, 1);
        chk("b_valid_c7", {63'd0, wb.out_valid}, 0);
        tick();
        chk("b_done_c8", {63'd0, done}, 0);
        chk("b_busy_c8", {63'd0, busy}, 0);
        check_line(6'd2);

        // Backpressure: sink stalls 5 cycles once the first beat appears.
        clear_mon();
        wb.out_ready = 1'b0;
        start_line(6'd2);
        n = 0;
        while (wb.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        chk("bp_valid_rise", {63'd0, wb.out_valid}, 1);
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_data", wb.out_data, 32'hA0);
            chk("bp_hold_idx", wb.out_idx, 0);
            tick();
        end
        chk("bp_reads_issued", n_iss, 2);
        chk("bp_raddr_stall", bram_raddr, 9);
        wb.out_ready = 1'b1;
        wait_done(1'b0, 50);
        tick();
        check_line(6'd2);
        chk("bp_max_outstanding_le2", (max_out <= 2), 1);

        // Pseudo-random ready over 50 lines.
        tot_done = 0;
        for (int l = 0; l < 50; l++) begin
            li = 6'($urandom_range(0, 63));
            clear_mon();
            wb.out_ready = 1'($urandom_range(0, 1));
            start_line(li);
            wait_done(1'b1, 400);
            tick();
            check_line(li);
            chk("rnd_max_outstanding_le2", (max_out <= 2), 1);
            tot_done += n_done;
        end
        chk("rnd_total_done", tot_done, 50);

        // Start while busy is ignored; start in the DONE cycle is ignored, accepted one cycle later.
        clear_mon();
        wb.out_ready = 1'b1;
        start_line(6'd2);
        tick();
        line_idx = 6'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(1'b0, 50);
        line_idx = 6'd5;
        start    = 1'b1;
        tick();
        chk("sib_start_in_done_ignored", {63'd0, busy}, 0);
        check_line(6'd2);
        tick();
        start = 1'b0;
        chk("sib_start_in_idle_taken", {63'd0, busy}, 1);
        clear_mon();
        wait_done(1'b0, 50);
        tick();
        check_line(6'd5);

        // Reset mid-line after beat 1 aborts the line.
        clear_mon();
        wb.out_ready = 1'b1;
        start_line(6'd3);
        n = 0;
        while (n_pop < 2 && n < 20) begin tick(); n++; end
        chk("mr_two_beats", n_pop, 2);
        #2 rstn = 1'b0;
        #1;
        chk("mr_busy", {63'd0, busy}, 0);
        chk("mr_done", {63'd0, done}, 0);
        chk("mr_valid", {63'd0, wb.out_valid}, 0);
        chk("mr_last", {63'd0, wb.out_last}, 0);
        chk("mr_data", wb.out_data, 0);
        chk("mr_idx", wb.out_idx, 0);
        chk("mr_raddr", bram_raddr, 0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        tick();
        chk("mr_no_done", n_done, 0);
        chk("mr_no_beat_after", {63'd0, wb.out_valid}, 0);
        clear_mon();
        start_line(6'd3);
        wait_done(1'b0, 50);
        tick();
        check_line(6'd3);

        // Highest line: addresses 252..255, no wrap into line 0.
        clear_mon();
        wb.out_ready = 1'b1;
        start_line(6'd63);
        chk("hi_raddr0", bram_raddr, 252);
        tick();
        chk("hi_raddr1", bram_raddr, 253);
        tick();
        chk("hi_raddr2", bram_raddr, 254);
        tick();
        chk("hi_raddr3", bram_raddr, 255);
        wait_done(1'b0, 50);
        tick();
        check_line(6'd63);
        chk("hi_raddr_no_wrap", bram_raddr, 255);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
